// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch and decode stages.
// The VEC_HI/VEC_LO fetch states exist only when FETCH_INT_VECTOR_EN is defined.
package cpu_pkg;

  localparam logic [4:0]  OP_LDM  = 5'b10001;
  localparam logic [4:0]  OP_SHL  = 5'b10100;
  localparam logic [4:0]  OP_SHR  = 5'b10101;
  localparam logic [15:0] NOP_ENC = 16'h4000;

  typedef enum logic [2:0] {
    BOOT_HI = 3'd0,
    BOOT_LO = 3'd1,
    RUN     = 3'd2,
    IMM     = 3'd3
`ifdef FETCH_INT_VECTOR_EN
    ,
    VEC_HI  = 3'd4,
    VEC_LO  = 3'd5
`endif
  } fetch_state_t;

  // True for opcodes that carry a second (immediate) word.
  function automatic logic is_two_word(input logic [15:0] word);
    logic r;
    case (word[15:11])
      OP_LDM, OP_SHL, OP_SHR: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID pipeline outputs of the fetch stage.
interface fetch_stage_if;

  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  // Fetch side: drives the memory address and the IF/ID register.
  modport master (
    output imem_addr,
    input  imem_data,
    output if_id_instr,
    output if_id_imm,
    output if_id_pc,
    output if_id_valid
  );

  // Memory/decode side.
  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_id_instr,
    input  if_id_imm,
    input  if_id_pc,
    input  if_id_valid
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold keeps everything, bubble injects a NOP
// while leaving the recorded pc untouched, otherwise loads a valid entry.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_ENC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_imm,
  input  logic [31:0] d_pc,
  output logic [15:0] q_instr,
  output logic [15:0] q_imm,
  output logic [31:0] q_pc,
  output logic        q_valid
);

  // IF/ID stage boundary: hold, bubble or load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_instr <= NOP_WORD;
      q_imm   <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        q_instr <= NOP_WORD;
        q_imm   <= '0;
        q_valid <= 1'b0;
      end else begin
        q_instr <= d_instr;
        q_imm   <= d_imm;
        q_pc    <= d_pc;
        q_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, boots from the reset vector,
// assembles two-word instructions and feeds the IF/ID register.
// Optional interrupt-vector fetch is compiled in with FETCH_INT_VECTOR_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [31:0] INT_VEC_ADDR   = 32'd2,
  parameter logic [15:0] NOP_WORD       = NOP_ENC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          jump_taken,
  input  logic [31:0]   jump_target,
  input  logic          pc_mem_valid,
  input  logic [31:0]   pc_mem,
  input  logic          int_vec_load,
  fetch_stage_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [15:0]  hold_instr_p0;
  logic [31:0]  hold_pc_p0;
  logic         redirect;
  logic         vec_req;

  logic         id_hold;
  logic         id_bubble;
  logic [15:0]  id_instr;
  logic [15:0]  id_imm;
  logic [31:0]  id_pc;

  assign pc_inc   = pc + 32'd1;
  assign redirect = pc_mem_valid | jump_taken;

`ifdef FETCH_INT_VECTOR_EN
  assign vec_req = int_vec_load;
`else
  logic unused_vec;
  assign vec_req    = 1'b0;
  assign unused_vec = ^{int_vec_load, INT_VEC_ADDR};
`endif

  // Memory address follows the FSM: vector halves while booting, pc otherwise.
  always_comb begin
    bus.imem_addr = pc;
    case (state)
      BOOT_HI: bus.imem_addr = RESET_VEC_ADDR;
      BOOT_LO: bus.imem_addr = RESET_VEC_ADDR + 32'd1;
`ifdef FETCH_INT_VECTOR_EN
      VEC_HI:  bus.imem_addr = INT_VEC_ADDR;
      VEC_LO:  bus.imem_addr = INT_VEC_ADDR + 32'd1;
`endif
      default: bus.imem_addr = pc;
    endcase
  end

  // IF/ID control: redirects beat stall, stall beats flush.
  always_comb begin
    id_hold   = 1'b0;
    id_bubble = 1'b0;
    id_instr  = bus.imem_data;
    id_imm    = '0;
    id_pc     = pc;
    if (redirect || vec_req) begin
      id_bubble = 1'b1;
    end else if (stall) begin
      id_hold = 1'b1;
    end else if (flush) begin
      id_bubble = 1'b1;
    end else begin
      case (state)
        RUN: id_bubble = is_two_word(bus.imem_data);
        IMM: begin
          id_instr = hold_instr_p0;
          id_imm   = bus.imem_data;
          id_pc    = hold_pc_p0;
        end
        default: id_bubble = 1'b1;
      endcase
    end
  end

  // PC / fetch FSM with the two-word holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT_HI;
      pc            <= RESET_VEC_ADDR;
      hold_instr_p0 <= '0;
      hold_pc_p0    <= '0;
    end else if (pc_mem_valid) begin
      pc            <= pc_mem;
      state         <= RUN;
      hold_instr_p0 <= '0;
      hold_pc_p0    <= '0;
    end else if (jump_taken) begin
      pc            <= jump_target;
      state         <= RUN;
      hold_instr_p0 <= '0;
      hold_pc_p0    <= '0;
`ifdef FETCH_INT_VECTOR_EN
    end else if (int_vec_load) begin
      state         <= VEC_HI;
      hold_instr_p0 <= '0;
      hold_pc_p0    <= '0;
`endif
    end else if (!stall) begin
      case (state)
        BOOT_HI: begin
          pc[31:16] <= bus.imem_data;
          state     <= BOOT_LO;
        end
        BOOT_LO: begin
          pc[15:0] <= bus.imem_data;
          state    <= RUN;
        end
        RUN: begin
          pc <= pc_inc;
          if (!flush && is_two_word(bus.imem_data)) begin
            hold_instr_p0 <= bus.imem_data;
            hold_pc_p0    <= pc;
            state         <= IMM;
          end
        end
        IMM: begin
          // Immediate consumed (or dropped on flush) either way.
          pc            <= pc_inc;
          state         <= RUN;
          hold_instr_p0 <= '0;
          hold_pc_p0    <= '0;
        end
`ifdef FETCH_INT_VECTOR_EN
        VEC_HI: begin
          pc[31:16] <= bus.imem_data;
          state     <= VEC_LO;
        end
        VEC_LO: begin
          pc[15:0] <= bus.imem_data;
          state    <= RUN;
        end
`endif
        default: state <= BOOT_HI;
      endcase
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .hold    (id_hold),
    .bubble  (id_bubble),
    .d_instr (id_instr),
    .d_imm   (id_imm),
    .d_pc    (id_pc),
    .q_instr (bus.if_id_instr),
    .q_imm   (bus.if_id_imm),
    .q_pc    (bus.if_id_pc),
    .q_valid (bus.if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a combinational 1K-word imem model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        pc_mem_valid;
  logic [31:0] pc_mem;
  logic        int_vec_load;
  logic [15:0] mem [0:1023];
  int          checks;
  int          passes;

  fetch_stage_if fif ();

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .pc_mem_valid (pc_mem_valid),
    .pc_mem       (pc_mem),
    .int_vec_load (int_vec_load),
    .bus          (fif.master)
  );

  assign fif.imem_data = mem[10'(fif.imem_addr % 32'd1024)];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL rst_valid got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_instr !== 16'h4000) $display("FAIL rst_instr got %h want 4000", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_imm !== 16'h0) $display("FAIL rst_imm got %h want 0", fif.if_id_imm); else passes++;
    checks++; if (fif.if_id_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", fif.if_id_pc); else passes++;
    checks++; if (fif.imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", fif.imem_addr); else passes++;
  endtask

  task automatic test_boot();
    mem[0] = 16'h0000; mem[1] = 16'h0020; mem[32'h20] = 16'h1111;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h1) $display("FAIL boot_lo_addr got %h want 1", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL boot_bubble1 got %h want 0", fif.if_id_valid); else passes++;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h20) $display("FAIL boot_run_addr got %h want 20", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL boot_bubble2 got %h want 0", fif.if_id_valid); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_valid !== 1'b1) $display("FAIL boot_first_valid got %h want 1", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_pc !== 32'h20) $display("FAIL boot_first_pc got %h want 20", fif.if_id_pc); else passes++;
    checks++; if (fif.if_id_instr !== 16'h1111) $display("FAIL boot_first_instr got %h want 1111", fif.if_id_instr); else passes++;
    checks++; if (fif.imem_addr !== 32'h21) $display("FAIL boot_next_addr got %h want 21", fif.imem_addr); else passes++;
  endtask

  task automatic test_ldm();
    reset = 1'b1;
    mem[32'h20] = 16'h8900; mem[32'h21] = 16'h1234;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h20) $display("FAIL ldm_addr0 got %h want 20", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL ldm_bubble got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_instr !== 16'h4000) $display("FAIL ldm_bubble_instr got %h want 4000", fif.if_id_instr); else passes++;
    checks++; if (fif.imem_addr !== 32'h21) $display("FAIL ldm_imm_addr got %h want 21", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h8900) $display("FAIL ldm_instr got %h want 8900", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_imm !== 16'h1234) $display("FAIL ldm_imm got %h want 1234", fif.if_id_imm); else passes++;
    checks++; if (fif.if_id_pc !== 32'h20) $display("FAIL ldm_pc got %h want 20", fif.if_id_pc); else passes++;
    checks++; if (fif.if_id_valid !== 1'b1) $display("FAIL ldm_valid got %h want 1", fif.if_id_valid); else passes++;
    checks++; if (fif.imem_addr !== 32'h22) $display("FAIL ldm_next_addr got %h want 22", fif.imem_addr); else passes++;
  endtask

  task automatic test_stall_jump();
    mem[32'h22] = 16'h0005; mem[32'h100] = 16'h0007;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fif.if_id_instr !== 16'h8900) $display("FAIL stall_instr[%0d] got %h want 8900", i, fif.if_id_instr); else passes++;
      checks++; if (fif.if_id_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %h want 1", i, fif.if_id_valid); else passes++;
      checks++; if (fif.imem_addr !== 32'h22) $display("FAIL stall_addr[%0d] got %h want 22", i, fif.imem_addr); else passes++;
    end
    jump_taken = 1'b1; jump_target = 32'h100;
    @(negedge clk);
    stall = 1'b0; jump_taken = 1'b0;
    checks++; if (fif.imem_addr !== 32'h100) $display("FAIL sj_addr got %h want 100", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL sj_bubble got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_instr !== 16'h4000) $display("FAIL sj_instr got %h want 4000", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h20) $display("FAIL sj_pc_kept got %h want 20", fif.if_id_pc); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h0007) $display("FAIL jt_instr got %h want 0007", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h100) $display("FAIL jt_pc got %h want 100", fif.if_id_pc); else passes++;
  endtask

  task automatic test_redirect_imm();
    mem[32'h40] = 16'hA123; mem[32'h41] = 16'h00FF; mem[32'h55] = 16'h0009;
    jump_taken = 1'b1; jump_target = 32'h40;
    @(negedge clk); jump_taken = 1'b0;
    checks++; if (fif.imem_addr !== 32'h40) $display("FAIL rdi_addr0 got %h want 40", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h41) $display("FAIL rdi_imm_addr got %h want 41", fif.imem_addr); else passes++;
    pc_mem_valid = 1'b1; pc_mem = 32'h55;
    @(negedge clk); pc_mem_valid = 1'b0;
    checks++; if (fif.imem_addr !== 32'h55) $display("FAIL rdi_addr got %h want 55", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL rdi_bubble got %h want 0", fif.if_id_valid); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h0009) $display("FAIL rdi_instr got %h want 0009", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h55) $display("FAIL rdi_pc got %h want 55", fif.if_id_pc); else passes++;
  endtask

  task automatic test_flush();
    mem[32'h56] = 16'h000A; mem[32'h57] = 16'hA800; mem[32'h58] = 16'hBEEF; mem[32'h59] = 16'h000D;
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL fl_run_valid got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_imm !== 16'h0) $display("FAIL fl_run_imm got %h want 0", fif.if_id_imm); else passes++;
    checks++; if (fif.if_id_pc !== 32'h55) $display("FAIL fl_run_pc got %h want 55", fif.if_id_pc); else passes++;
    checks++; if (fif.imem_addr !== 32'h57) $display("FAIL fl_run_addr got %h want 57", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h58) $display("FAIL fl_shr_addr got %h want 58", fif.imem_addr); else passes++;
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL fl_imm_valid got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.imem_addr !== 32'h59) $display("FAIL fl_imm_addr got %h want 59", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h000D) $display("FAIL fl_after_instr got %h want 000D", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h59) $display("FAIL fl_after_pc got %h want 59", fif.if_id_pc); else passes++;
  endtask

  task automatic test_wrap();
    mem[1023] = 16'h000B;
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFF;
    @(negedge clk); jump_taken = 1'b0;
    checks++; if (fif.imem_addr !== 32'hFFFF_FFFF) $display("FAIL wrap_addr0 got %h want ffffffff", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h000B) $display("FAIL wrap_instr got %h want 000B", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'hFFFF_FFFF) $display("FAIL wrap_pc got %h want ffffffff", fif.if_id_pc); else passes++;
    checks++; if (fif.imem_addr !== 32'h0) $display("FAIL wrap_next got %h want 0", fif.imem_addr); else passes++;
  endtask

  task automatic test_int_vec();
    mem[2] = 16'h0000; mem[3] = 16'h0300; mem[32'h300] = 16'h000C;
    int_vec_load = 1'b1;
    @(negedge clk); int_vec_load = 1'b0;
`ifdef FETCH_INT_VECTOR_EN
    checks++; if (fif.imem_addr !== 32'h2) $display("FAIL iv_hi_addr got %h want 2", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL iv_bubble1 got %h want 0", fif.if_id_valid); else passes++;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h3) $display("FAIL iv_lo_addr got %h want 3", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL iv_bubble2 got %h want 0", fif.if_id_valid); else passes++;
    @(negedge clk);
    checks++; if (fif.imem_addr !== 32'h300) $display("FAIL iv_run_addr got %h want 300", fif.imem_addr); else passes++;
    @(negedge clk);
    checks++; if (fif.if_id_instr !== 16'h000C) $display("FAIL iv_instr got %h want 000C", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h300) $display("FAIL iv_pc got %h want 300", fif.if_id_pc); else passes++;
`else
    checks++; if (fif.imem_addr !== 32'h1) $display("FAIL iv_ignored_addr got %h want 1", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b1) $display("FAIL iv_ignored_valid got %h want 1", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_pc !== 32'h0) $display("FAIL iv_ignored_pc got %h want 0", fif.if_id_pc); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    #2 reset = 1'b1;
    #1;
    checks++; if (fif.imem_addr !== 32'h0) $display("FAIL rmid_addr got %h want 0", fif.imem_addr); else passes++;
    checks++; if (fif.if_id_valid !== 1'b0) $display("FAIL rmid_valid got %h want 0", fif.if_id_valid); else passes++;
    checks++; if (fif.if_id_instr !== 16'h4000) $display("FAIL rmid_instr got %h want 4000", fif.if_id_instr); else passes++;
    checks++; if (fif.if_id_pc !== 32'h0) $display("FAIL rmid_pc got %h want 0", fif.if_id_pc); else passes++;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    jump_taken = 1'b0; jump_target = '0;
    pc_mem_valid = 1'b0; pc_mem = '0; int_vec_load = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_boot();
    test_ldm();
    test_stall_jump();
    test_redirect_imm();
    test_flush();
    test_wrap();
    test_int_vec();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode-stage control FSM.
- Owns the 32-bit word-addressed PC and reads 16-bit words from instruction memory.
- Assembles two-word instructions (LDM, SHL, SHR) into instruction plus immediate.
- Loads the PC from the reset vector, and drives the IF/ID pipeline register consumed by decode.

Parameters:
- RESET_VEC_ADDR, 0, imem word address of reset-vector high half; low half at RESET_VEC_ADDR+1.
- INT_VEC_ADDR, 2, imem word address of interrupt-vector high half; low half at INT_VEC_ADDR+1.
- NOP_WORD, 16'h4000, instruction word injected on bubbles/flushes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC, FSM and IF/ID (hazard unit)
- flush  in  1  replace the next IF/ID contents with a bubble
- jump_taken  in  1  redirect from execute
- jump_target  in  32  redirect address
- pc_mem_valid  in  1  RET/RETI: PC restored from memory stage
- pc_mem  in  32  restored PC
- int_vec_load  in  1  pulse: fetch ISR address (optional feature)
- imem_addr  out  32  instruction-memory word address (combinational from PC/FSM)
- imem_data  in  16  instruction-memory read data, same-cycle
- if_id_instr  out  16  instruction to decode
- if_id_imm  out  16  immediate word (valid for two-word opcodes)
- if_id_pc  out  32  address of the instruction's first word
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset values (asynchronous):
  - state = BOOT_HI; pc = RESET_VEC_ADDR.
  - if_id_instr = NOP_WORD; if_id_imm = 0; if_id_pc = 0; if_id_valid = 0.
  - Holding registers are cleared.
- States:
  - BOOT_HI: imem_addr = RESET_VEC_ADDR; capture imem_data into pc[31:16]; go to BOOT_LO.
  - BOOT_LO: imem_addr = RESET_VEC_ADDR+1; capture imem_data into pc[15:0]; go to RUN. IF/ID is a bubble throughout boot.
  - RUN: imem_addr = pc.
    - Two-word opcodes are instr[15:11] in {10001, 10100, 10101}.
    - If the word is two-word: latch it and its pc into the hold registers, pc += 1, IF/ID gets a bubble, go to IMM.
    - Otherwise: IF/ID <= {word, imm = 0, pc, valid = 1}; pc += 1.
  - IMM: imem_addr = pc; IF/ID <= {held word, imm = imem_data, held pc, valid = 1}; pc += 1; go to RUN.
  - VEC_HI / VEC_LO: as the boot states, but at INT_VEC_ADDR / INT_VEC_ADDR+1; then go to RUN.
- Latency:
  - Single-word instruction: 1 cycle from imem read to IF/ID.
  - Two-word instruction: 2 cycles, with one bubble.
  - Boot takes 2 cycles; the first real fetch happens on the 3rd cycle after reset deasserts.
- Arithmetic: pc += 1, modulo 2^32; 32'hFFFFFFFF wraps to 0 with no flag.
- Priority, highest first: reset, pc_mem_valid, jump_taken, int_vec_load, stall, flush, normal.
  - pc_mem_valid: pc <= pc_mem; state <= RUN; hold registers discarded; IF/ID bubble. Applies even mid-IMM or during boot.
  - jump_taken: pc <= jump_target; otherwise identical to pc_mem_valid.
  - int_vec_load: state <= VEC_HI; IF/ID bubble; any pending IMM is discarded.
  - stall: pc, state, hold registers and IF/ID all unchanged; imem_addr is still driven.
  - flush: IF/ID bubble, and the current fetch result is dropped.
    - In RUN, pc still advances.
    - In IMM, the held word is discarded, pc advances past the immediate, and the state goes to RUN.
- Redirect asserted together with stall: the redirect wins.
- Reset asserted mid-operation: immediate return to reset values, from any state.
- Bubble definition: if_id_instr = NOP_WORD, if_id_imm = 0, if_id_valid = 0; if_id_pc is unchanged.

Optional Feature:
- Macro: FETCH_INT_VECTOR_EN.
- Defined: int_vec_load is honoured, and the VEC_HI/VEC_LO states exist.
- Undefined: int_vec_load is ignored, VEC_* states are not compiled, and INT_VEC_ADDR is unused.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum {BOOT_HI, BOOT_LO, RUN, IMM, VEC_HI, VEC_LO};
  - opcode constants OP_LDM = 5'b10001, OP_SHL = 5'b10100, OP_SHR = 5'b10101;
  - NOP encoding constant;
  - the is_two_word() function, shared with decode.
- One natural sub-module, if_id_reg: the pipeline register with stall/bubble controls. The PC/FSM logic stays in fetch_stage.

Test Plan:
- Boot: imem[0] = 16'h0000, imem[1] = 16'h0020, then reset -> 2 bubble cycles; then imem_addr = 32'h20, and if_id_pc = 32'h20 one cycle later with valid = 1.
- LDM assembly: imem[0x20] = 16'h8900, imem[0x21] = 16'h1234 -> one bubble, then if_id_instr = 16'h8900, imm = 16'h1234, if_id_pc = 32'h20; next fetch address is 32'h22.
- Stall then jump: stall for 3 cycles -> IF/ID frozen and pc constant; then stall plus jump_taken with target 32'h100 -> pc = 32'h100 and IF/ID bubble.
- Redirect mid-IMM: LDM fetched, then pc_mem_valid with pc_mem = 32'h55 during IMM -> held word dropped, no valid LDM emitted, next fetch from 32'h55.
- Wrap: jump to 32'hFFFFFFFF with a single-word instruction there -> next imem_addr = 32'h0.
- With FETCH_INT_VECTOR_EN: int_vec_load while imem[2] = 0, imem[3] = 16'h0300 -> 2 bubbles, then fetch from 32'h300. Without the macro: no effect.
